// File: rtl/poly_eval_if.sv
// poly_eval_if: valid/ready sample stream into poly_eval_pipe and result stream out of it.
// The slave view belongs to the evaluator, the master view to the source/sink around it.
interface poly_eval_if #(
    parameter int IN_W  = 32'sd10,
    parameter int OUT_W = 32'sd10
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_ovf;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_ovf
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_ovf
    );
endinterface

// File: rtl/poly_eval_pipe.sv
// poly_eval_pipe: f(x) = C3*x^3 + C2*x^2 + C1*x + C0 by Horner's rule, three multiply-add stages
// plus an output-format stage. Define POLY_SAT_EN to saturate overflowed samples instead of zeroing them.
module poly_eval_pipe #(
    parameter int        IN_W   = 32'sd10,
    parameter int        IN_F   = 32'sd7,
    parameter int        OUT_W  = 32'sd10,
    parameter int        OUT_F  = 32'sd6,
    parameter int        COEF_W = 32'sd12,
    parameter int        COEF_F = 32'sd9,
    parameter int        ACC_W  = 32'sd16,
    parameter int        ACC_F  = 32'sd10,
    parameter int signed C3     = 32'sd435,
    parameter int signed C2     = 32'sd0,
    parameter int signed C1     = 32'sd0,
    parameter int signed C0     = 32'sd512
) (
    input  logic       clk,
    input  logic       reset_n,
    poly_eval_if.slave stream
);
    // Wide enough for any stage product plus the added constant without loss.
    localparam int FW  = ACC_W + IN_W + COEF_W + 2;
    localparam int SH1 = COEF_F + IN_F - ACC_F;
    localparam int SHC = ACC_F - COEF_F;
    localparam int SHY = ACC_F - OUT_F;

    typedef logic signed [FW-1:0] wide_t;

    localparam wide_t ACC_HI = wide_t'((64'sd1 <<< (ACC_W - 1)) - 64'sd1);
    localparam wide_t ACC_LO = -ACC_HI - wide_t'(64'sd1);
    localparam wide_t OUT_HI = wide_t'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam wide_t OUT_LO = -OUT_HI - wide_t'(64'sd1);

    localparam logic signed [COEF_W-1:0] K3 = COEF_W'(C3);
    localparam logic signed [COEF_W-1:0] K2 = COEF_W'(C2);
    localparam logic signed [COEF_W-1:0] K1 = COEF_W'(C1);
    localparam logic signed [COEF_W-1:0] K0 = COEF_W'(C0);

    localparam wide_t C2_ACC = wide_t'(K2) <<< SHC;
    localparam wide_t C1_ACC = wide_t'(K1) <<< SHC;
    localparam wide_t C0_ACC = wide_t'(K0) <<< SHC;

    localparam logic [OUT_W-1:0] OUT_POS = {1'b0, {(OUT_W - 1){1'b1}}};
    localparam logic [OUT_W-1:0] OUT_NEG = {1'b1, {(OUT_W - 1){1'b0}}};

`ifdef POLY_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    function automatic logic outside(input wide_t v, input wide_t lo, input wide_t hi);
        return (v < lo) || (v > hi);
    endfunction

    function automatic wide_t widen_acc(input logic [ACC_W-1:0] a);
        return wide_t'($signed(a));
    endfunction

    logic             v1_r, v2_r, v3_r, out_valid_r;
    logic [ACC_W-1:0] a1_r, a2_r, a3_r;
    logic [IN_W-1:0]  x1_r, x2_r;
    logic             o1_r, o2_r, o3_r, out_ovf_r;
    logic             n1_r, n2_r, n3_r;
    logic [OUT_W-1:0] out_data_r;

    logic             advance_s;
    wide_t            f1_s, f2_s, f3_s, fy_s;
    logic             ov1_s, ov2_s, ov3_s, ovy_s;
    logic             ovf_y_s, neg_y_s;
    logic [OUT_W-1:0] y_s;

    assign advance_s        = ~out_valid_r | stream.out_ready;
    assign stream.in_ready  = advance_s;
    assign stream.out_valid = out_valid_r;
    assign stream.out_data  = out_data_r;
    assign stream.out_ovf   = out_ovf_r;

    // Full-precision stage arithmetic, range checks and output formatting.
    always_comb begin
        f1_s    = ((wide_t'(K3) * wide_t'($signed(stream.in_data))) >>> SH1) + C2_ACC;
        f2_s    = ((widen_acc(a1_r) * wide_t'($signed(x1_r))) >>> IN_F) + C1_ACC;
        f3_s    = ((widen_acc(a2_r) * wide_t'($signed(x2_r))) >>> IN_F) + C0_ACC;
        fy_s    = widen_acc(a3_r) >>> SHY;
        ov1_s   = outside(f1_s, ACC_LO, ACC_HI);
        ov2_s   = outside(f2_s, ACC_LO, ACC_HI);
        ov3_s   = outside(f3_s, ACC_LO, ACC_HI);
        ovy_s   = outside(fy_s, OUT_LO, OUT_HI);
        ovf_y_s = o3_r | ovy_s;
        // Saturation direction follows the first stage that went out of range.
        neg_y_s = o3_r ? n3_r : fy_s[FW-1];
        if (ovf_y_s) begin
            y_s = SAT_EN ? (neg_y_s ? OUT_NEG : OUT_POS) : {OUT_W{1'b0}};
        end else begin
            y_s = fy_s[OUT_W-1:0];
        end
    end

    // Pipeline registers: all stages shift together on advance and hold otherwise.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            v1_r        <= 1'b0;
            v2_r        <= 1'b0;
            v3_r        <= 1'b0;
            out_valid_r <= 1'b0;
            a1_r        <= {ACC_W{1'b0}};
            a2_r        <= {ACC_W{1'b0}};
            a3_r        <= {ACC_W{1'b0}};
            x1_r        <= {IN_W{1'b0}};
            x2_r        <= {IN_W{1'b0}};
            o1_r        <= 1'b0;
            o2_r        <= 1'b0;
            o3_r        <= 1'b0;
            n1_r        <= 1'b0;
            n2_r        <= 1'b0;
            n3_r        <= 1'b0;
            out_ovf_r   <= 1'b0;
            out_data_r  <= {OUT_W{1'b0}};
        end else if (advance_s) begin
            v1_r        <= stream.in_valid;
            a1_r        <= f1_s[ACC_W-1:0];
            x1_r        <= stream.in_data;
            o1_r        <= ov1_s;
            n1_r        <= f1_s[FW-1];

            v2_r        <= v1_r;
            a2_r        <= f2_s[ACC_W-1:0];
            x2_r        <= x1_r;
            o2_r        <= o1_r | ov2_s;
            n2_r        <= o1_r ? n1_r : f2_s[FW-1];

            v3_r        <= v2_r;
            a3_r        <= f3_s[ACC_W-1:0];
            o3_r        <= o2_r | ov3_s;
            n3_r        <= o2_r ? n2_r : f3_s[FW-1];

            out_valid_r <= v3_r;
            out_data_r  <= y_s;
            out_ovf_r   <= ovf_y_s;
        end
    end
endmodule
